// File: rtl/shot_hit_pkg.sv
// Shared types and constants for the shot/target hit arbiter.
package shot_hit_pkg;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    FLYING   = 2'd1,
    HIT      = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  localparam int MAX_MON = 8;
  localparam int SCORE_W = 8;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/shot_hit_arbiter_latch.sv
// hit_frame_latch: OR-accumulates monster overlaps for one frame and hands the
// mask over as a one-clock commit at the frame boundary.
module hit_frame_latch #(
  parameter int N_MON = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_en_i,
  input  logic             shot_dr_i,
  input  logic [N_MON-1:0] monster_dr_i,
  input  logic             commit_i,
  output logic             commit_o,
  output logic [N_MON-1:0] mask_o
);

  logic [N_MON-1:0] latch_q, latch_d;
  logic [N_MON-1:0] mask_q;
  logic             commit_q;

  // Overlaps on the commit cycle itself still belong to the committed frame.
  assign latch_d = latch_q | ((acc_en_i && shot_dr_i) ? monster_dr_i : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q  <= '0;
      mask_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= commit_i;
      if (commit_i) begin
        mask_q  <= latch_d;
        latch_q <= '0;
      end else begin
        latch_q <= latch_d;
      end
    end
  end

  assign commit_o = commit_q;
  assign mask_o   = mask_q;

endmodule

// File: rtl/shot_hit_arbiter.sv
// shot_hit_arbiter: detects shot/target overlap, commits kills per frame and
// gates re-fire with a frame-count cooldown. Optional scoring under SHOT_SCORE_EN.
import shot_hit_pkg::*;

module shot_hit_arbiter #(
  parameter int                 N_MON         = 4,
  parameter int                 RELOAD_FRAMES = 30,
  parameter logic [SCORE_W-1:0] MON_SCORE     = 8'd250
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               shot_dr,
  input  logic [N_MON-1:0]   monster_dr,
  input  logic               wall_dr,
  input  logic               shot_fired,
  output logic               fireCollision,
  output logic [N_MON-1:0]   monster_kill,
  output logic               fire_ready,
  output logic [SCORE_W-1:0] score_add
);

  localparam logic [CNT_W-1:0] RELOAD_CNT = CNT_W'(RELOAD_FRAMES);

  if (N_MON < 1 || N_MON > MAX_MON) begin : g_bad_n_mon
    $error("N_MON out of range");
  end
  if (RELOAD_FRAMES < 1 || RELOAD_FRAMES > 255) begin : g_bad_reload
    $error("RELOAD_FRAMES out of range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire_ready_q;
  logic             fire_coll_q;
  logic             hit_c;
  logic             acc_en;
  logic             commit;
  logic             commit_pulse;
  logic [N_MON-1:0] commit_mask;

  assign hit_c  = shot_dr & ((|monster_dr) | wall_dr);
  assign acc_en = (state_q == FLYING) || (state_q == HIT);
  assign commit = startOfFrame && (state_q == HIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARMED:    if (shot_fired) state_d = FLYING;
      FLYING:   if (hit_c) state_d = HIT;
      HIT: begin
        if (startOfFrame) begin
          state_d = COOLDOWN;
          cnt_d   = RELOAD_CNT;
        end
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= 1) state_d = ARMED;
        end
      end
      default:  state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARMED;
      cnt_q        <= '0;
      fire_ready_q <= 1'b1;
      fire_coll_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fire_ready_q <= (state_d == ARMED);
      fire_coll_q  <= (state_q == FLYING) && hit_c;
    end
  end

  hit_frame_latch #(.N_MON(N_MON)) u_latch (
    .clk          (clk),
    .reset        (reset),
    .acc_en_i     (acc_en),
    .shot_dr_i    (shot_dr),
    .monster_dr_i (monster_dr),
    .commit_i     (commit),
    .commit_o     (commit_pulse),
    .mask_o       (commit_mask)
  );

  assign fireCollision = fire_coll_q;
  assign fire_ready    = fire_ready_q;
  assign monster_kill  = commit_pulse ? commit_mask : '0;

`ifdef SHOT_SCORE_EN
  logic [3:0]  kill_cnt;
  logic [11:0] score_raw;

  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < N_MON; i++) kill_cnt = kill_cnt + 4'(monster_kill[i]);
  end

  assign score_raw = 12'(MON_SCORE) * 12'(kill_cnt);
  assign score_add = (score_raw > 12'd255) ? 8'hFF : score_raw[7:0];
`else
  assign score_add = '0;
`endif

endmodule

// File: tb/tb_shot_hit_arbiter.sv
// Directed bench for shot_hit_arbiter (N_MON=4, RELOAD_FRAMES=3).
module tb_shot_hit_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0;
  logic       shot_dr = 1'b0;
  logic [3:0] mon = 4'b0;
  logic       wall = 1'b0;
  logic       fired = 1'b0;
  logic       fc;
  logic [3:0] kill;
  logic       ready;
  logic [7:0] score;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SHOT_SCORE_EN
  localparam logic [7:0] SC_ONE = 8'd250;
  localparam logic [7:0] SC_TWO = 8'hFF;
`else
  localparam logic [7:0] SC_ONE = 8'd0;
  localparam logic [7:0] SC_TWO = 8'd0;
`endif

  shot_hit_arbiter #(.N_MON(4), .RELOAD_FRAMES(3), .MON_SCORE(8'd250)) dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (sof),
    .shot_dr       (shot_dr),
    .monster_dr    (mon),
    .wall_dr       (wall),
    .shot_fired    (fired),
    .fireCollision (fc),
    .monster_kill  (kill),
    .fire_ready    (ready),
    .score_add     (score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; sof = 0; shot_dr = 0; mon = '0; wall = 0; fired = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic fire_shot();
    fired = 1'b1; tick(); fired = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick();
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", ready); end
    n_chk++; if ({fc, kill, score} !== 13'd0) begin n_fail++; $display("FAIL rst_outs got %b/%b/%h want 0", fc, kill, score); end
    reset = 1'b0; tick();
    fire_shot();
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_fly_ready got %b want 0", ready); end
    shot_dr = 1; mon = 4'b0010; tick(); shot_dr = 0; mon = '0;
    #3 reset = 1'b1; #1;
    n_chk++; if ({fc, kill, ready} !== 6'b000001) begin n_fail++; $display("FAIL rst_mid got fc=%b kill=%b rdy=%b want 0/0000/1", fc, kill, ready); end
    @(posedge clk); #1 reset = 1'b0;
    sof = 1; tick(); sof = 0;
    n_chk++; if (kill !== 4'b0) begin n_fail++; $display("FAIL rst_no_kill got %b want 0000", kill); end
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_after_ready got %b want 1", ready); end
  endtask

  task automatic test_single_hit();
    do_reset(); fire_shot();
    shot_dr = 1; mon = 4'b0100;
    n_chk++; if (fc !== 1'b0) begin n_fail++; $display("FAIL single_fc_early got %b want 0", fc); end
    tick(); shot_dr = 0; mon = '0;
    n_chk++; if (fc !== 1'b1) begin n_fail++; $display("FAIL single_fc got %b want 1", fc); end
    tick();
    n_chk++; if (fc !== 1'b0) begin n_fail++; $display("FAIL single_fc_once got %b want 0", fc); end
    shot_dr = 1; mon = 4'b0100; tick(); shot_dr = 0; mon = '0;
    n_chk++; if (fc !== 1'b0) begin n_fail++; $display("FAIL single_fc_absorb got %b want 0", fc); end
    n_chk++; if (kill !== 4'b0) begin n_fail++; $display("FAIL single_kill_early got %b want 0000", kill); end
    sof = 1; tick(); sof = 0;
    n_chk++; if (kill !== 4'b0100) begin n_fail++; $display("FAIL single_kill got %b want 0100", kill); end
    n_chk++; if (score !== SC_ONE) begin n_fail++; $display("FAIL single_score got %h want %h", score, SC_ONE); end
    tick();
    n_chk++; if (kill !== 4'b0) begin n_fail++; $display("FAIL single_kill_pulse got %b want 0000", kill); end
  endtask

  task automatic test_multi_hit();
    do_reset(); fire_shot();
    shot_dr = 1; mon = 4'b0001; tick();
    n_chk++; if (fc !== 1'b1) begin n_fail++; $display("FAIL multi_fc got %b want 1", fc); end
    mon = 4'b1000; tick(); shot_dr = 0; mon = '0;
    n_chk++; if (fc !== 1'b0) begin n_fail++; $display("FAIL multi_fc_once got %b want 0", fc); end
    sof = 1; tick(); sof = 0;
    n_chk++; if (kill !== 4'b1001) begin n_fail++; $display("FAIL multi_kill got %b want 1001", kill); end
    n_chk++; if (score !== SC_TWO) begin n_fail++; $display("FAIL multi_score got %h want %h", score, SC_TWO); end
  endtask

  task automatic test_wall_hit();
    do_reset(); fire_shot();
    shot_dr = 1; wall = 1; tick(); shot_dr = 0; wall = 0;
    n_chk++; if (fc !== 1'b1) begin n_fail++; $display("FAIL wall_fc got %b want 1", fc); end
    mon = 4'b0010; tick(); mon = '0;
    sof = 1; tick(); sof = 0;
    n_chk++; if (kill !== 4'b0) begin n_fail++; $display("FAIL wall_kill got %b want 0000", kill); end
    n_chk++; if (score !== 8'd0) begin n_fail++; $display("FAIL wall_score got %h want 00", score); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL wall_cooldown got %b want 0", ready); end
  endtask

  task automatic test_cooldown();
    do_reset(); fire_shot();
    shot_dr = 1; mon = 4'b0001; tick(); shot_dr = 0; mon = '0;
    sof = 1; tick(); sof = 0;
    for (int i = 1; i <= 3; i++) begin
      fired = 1; tick(); fired = 0;
      n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL cool_fire_ignored[%0d] got %b want 0", i, ready); end
      sof = 1; tick(); sof = 0;
      n_chk++; if (ready !== (i == 3)) begin n_fail++; $display("FAIL cool_ready[%0d] got %b want %b", i, ready, (i == 3)); end
    end
    fire_shot();
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL cool_refire got %b want 0", ready); end
  endtask

  task automatic test_simultaneous();
    do_reset(); fire_shot();
    shot_dr = 1; mon = 4'b0010; sof = 1; tick(); shot_dr = 0; mon = '0; sof = 0;
    n_chk++; if (fc !== 1'b1) begin n_fail++; $display("FAIL simul_fc got %b want 1", fc); end
    n_chk++; if (kill !== 4'b0) begin n_fail++; $display("FAIL simul_no_commit got %b want 0000", kill); end
    tick();
    sof = 1; tick(); sof = 0;
    n_chk++; if (kill !== 4'b0010) begin n_fail++; $display("FAIL simul_kill got %b want 0010", kill); end
  endtask

  task automatic test_no_hit();
    do_reset(); fire_shot();
    shot_dr = 1; tick(); shot_dr = 0; mon = 4'b1111; tick(); mon = '0;
    for (int i = 0; i < 4; i++) begin
      sof = 1; tick(); sof = 0; tick();
    end
    n_chk++; if ({fc, kill, ready} !== 6'b0) begin n_fail++; $display("FAIL nohit_outs got fc=%b kill=%b rdy=%b want 0", fc, kill, ready); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_multi_hit();
    test_wall_hit();
    test_cooldown();
    test_simultaneous();
    test_no_hit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
